// File: rtl/cgate_handshake_seq.sv
// cgate_handshake_seq
// Drives the two inputs of one Muller C-element through full 4-phase cycles
// (rise F, rise S, fall F, fall S). After each step it checks the cell output.
// A single-input change must leave c unchanged for SETTLE cycles. Once both
// inputs agree, c must follow within TIMEOUT cycles.
//
// Optional feature: define CGSEQ_LATENCY_EN to track the worst-case switch
// latency in max_lat. When it is undefined, max_lat is tied to 0.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       run request, sampled only in IDLE
//   iterations  number of 4-phase cycles (0 = immediate done)
//   b_first     0: A is the first input to change, 1: B first (latched at start)
//   c_in        C-element output, asynchronous to clk
//   a_out/b_out C-element input drives
//   busy        run in progress
//   done        one-cycle pulse on successful completion
//   error       sticky fail flag, cleared by the next accepted start
//   err_code    0 none, 1 c high at start, 2 hold violation, 3 switch timeout
//   pass_cnt    completed good cycles (saturating)
//   max_lat     worst-case switch latency in cycles, including the 2-cycle sync
module cgate_handshake_seq #(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] iterations,
  input  logic             b_first,
  input  logic             c_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] max_lat
);

  localparam int unsigned WcntW = $clog2(TIMEOUT + 1);
  localparam logic [WcntW-1:0] SettleLast = WcntW'(SETTLE - 1);
  localparam logic [WcntW-1:0] TimeoutCnt = WcntW'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle, StPre, StR1, StR2, StF1, StF2, StDone, StErr
  } state_e;

  state_e           state_q, state_d;
  logic             c_meta_q, c_s_q;
  logic [WcntW-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic             b_first_q, b_first_d;
  logic             error_q, error_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             a_q, b_q, a_d, b_d;
  logic             drv_f, drv_s;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    pass_cnt_d  = pass_cnt_q;
    b_first_d   = b_first_q;
    error_d     = error_q;
    err_code_d  = err_code_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          remaining_d = iterations;
          b_first_d   = b_first;
          error_d     = 1'b0;
          err_code_d  = 2'd0;
          pass_cnt_d  = '0;
          state_d     = (iterations == '0) ? StDone : StPre;
        end
      end
      StPre: begin
        if (c_s_q) begin
          state_d    = StErr;
          err_code_d = 2'd1;
        end else if (wcnt_q == SettleLast) begin
          state_d = StR1;
        end
      end
      StR1: begin
        if (c_s_q) begin
          state_d    = StErr;
          err_code_d = 2'd2;
        end else if (wcnt_q == SettleLast) begin
          state_d = StR2;
        end
      end
      StR2: begin
        // A switch seen in the timeout cycle still counts as a pass.
        if (c_s_q) begin
          state_d = StF1;
        end else if (wcnt_q >= TimeoutCnt) begin
          state_d    = StErr;
          err_code_d = 2'd3;
        end
      end
      StF1: begin
        if (!c_s_q) begin
          state_d    = StErr;
          err_code_d = 2'd2;
        end else if (wcnt_q == SettleLast) begin
          state_d = StF2;
        end
      end
      StF2: begin
        if (!c_s_q) begin
          if (pass_cnt_q != {CNT_W{1'b1}}) pass_cnt_d = pass_cnt_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          state_d     = (remaining_q == CNT_W'(1)) ? StDone : StR1;
        end else if (wcnt_q >= TimeoutCnt) begin
          state_d    = StErr;
          err_code_d = 2'd3;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_d == StErr) error_d = 1'b1;

    if (state_d != state_q) wcnt_d = '0;
    else if (wcnt_q == {WcntW{1'b1}}) wcnt_d = wcnt_q;
    else wcnt_d = wcnt_q + 1'b1;

    // The drive is registered from the next state, so a/b follow the state entry.
    drv_f = 1'b0;
    drv_s = 1'b0;
    unique case (state_d)
      StR1:    drv_f = 1'b1;
      StR2:    begin drv_f = 1'b1; drv_s = 1'b1; end
      StF1:    drv_s = 1'b1;
      default: ;
    endcase
    a_d = b_first_d ? drv_s : drv_f;
    b_d = b_first_d ? drv_f : drv_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_meta_q    <= 1'b0;
      c_s_q       <= 1'b0;
      state_q     <= StIdle;
      wcnt_q      <= '0;
      remaining_q <= '0;
      pass_cnt_q  <= '0;
      b_first_q   <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= 2'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
    end else begin
      c_meta_q    <= c_in;
      c_s_q       <= c_meta_q;
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      remaining_q <= remaining_d;
      pass_cnt_q  <= pass_cnt_d;
      b_first_q   <= b_first_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      a_q         <= a_d;
      b_q         <= b_d;
    end
  end

`ifdef CGSEQ_LATENCY_EN
  logic [CNT_W-1:0] max_lat_q, max_lat_d, lat_now;
  logic             switched;

  always_comb begin
    switched  = ((state_q == StR2) && c_s_q) || ((state_q == StF2) && !c_s_q);
    lat_now   = CNT_W'(wcnt_q);
    max_lat_d = max_lat_q;
    if ((state_q == StIdle) && start) max_lat_d = '0;
    else if (switched && (lat_now > max_lat_q)) max_lat_d = lat_now;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) max_lat_q <= '0;
    else max_lat_q <= max_lat_d;
  end

  assign max_lat = max_lat_q;
`else
  assign max_lat = '0;
`endif

  assign a_out    = a_q;
  assign b_out    = b_q;
  assign busy     = (state_q == StPre) || (state_q == StR1) || (state_q == StR2) ||
                    (state_q == StF1) || (state_q == StF2);
  assign done     = (state_q == StDone);
  assign error    = error_q;
  assign err_code = err_code_q;
  assign pass_cnt = pass_cnt_q;

endmodule
